dl_port_router: RTL and testbench

- Generalised successor to the per-game ioctl-to-SDRAM download glue.
- Routes data_io download bytes to NPORTS SDRAM write ports. Each port has a parametrised base address and size window.
- Uses the toggle req/ack handshake. Optionally packs byte pairs into 16-bit words, and detects overruns.
- Sequences ROM-loaded status and the core reset. Sits between data_io and sdram in every arcade top level.

---
 rtl/dl_port_router.sv | 178 +++++++++++++++++
 tb/tb_dl_port_router.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_port_router.sv
// Routes data_io download bytes into per-port SDRAM windows over toggle req/ack,
// optionally pairing bytes into words, and sequences rom_loaded / core_reset.
//
// state | meaning
// IDLE  | no download in progress
// LOAD  | download active, routing byte strobes to hit ports
// FLUSH | download ended, emitting any half-filled words (lo byte only)
// DRAIN | waiting for every port's outstanding request to be acknowledged
// DONE  | one cycle to raise rom_loaded, then back to IDLE
module dl_port_router #(
    parameter int                   NPORTS      = 2,
    parameter int                   AW          = 25,
    parameter logic [NPORTS*AW-1:0] REGION_BASE = {25'h0E000, 25'h00000},
    parameter logic [NPORTS*AW-1:0] REGION_SIZE = {25'h1A000, 25'h0E000},
    parameter logic [7:0]           DL_INDEX    = 8'd0,
    parameter bit                   PACK        = 1'b1
) (
    input  logic                     clk_sys,
    input  logic                     res_n,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [AW-1:0]            ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    input  logic                     ext_reset,
    output logic [NPORTS-1:0]        port_req,
    input  logic [NPORTS-1:0]        port_ack,
    output logic [NPORTS-1:0]        port_we,
    output logic [NPORTS*(AW-1)-1:0] port_a,
    output logic [NPORTS*2-1:0]      port_ds,
    output logic [NPORTS*16-1:0]     port_d,
    output logic                     rom_loaded,
    output logic                     core_reset,
    output logic                     overrun
);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_t;

    state_t              state;
    logic                wr_last;
    logic                dl_act_q;
    logic                dl_act;
    logic                dl_rise;
    logic                strobe;

    logic [NPORTS-1:0]   hold_v;
    logic [AW-2:0]       hold_a [NPORTS];
    logic [7:0]          hold_d [NPORTS];

    logic [AW:0]         off_ext [NPORTS];
    logic [NPORTS-1:0]   hit;
    logic [NPORTS-1:0]   pend;
    logic [NPORTS-1:0]   iss;
    logic [AW-2:0]       iss_a [NPORTS];
    logic [1:0]          iss_ds [NPORTS];
    logic [15:0]         iss_d [NPORTS];
    logic [NPORTS-1:0]   hold_ld;
    logic [NPORTS-1:0]   hold_clr;

    assign dl_act  = ioctl_download & (ioctl_index == DL_INDEX);
    assign dl_rise = dl_act & ~dl_act_q;
    assign strobe  = ioctl_wr & ~wr_last & dl_act;

    // Offset computed one bit wider so the borrow marks addresses below the base.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            off_ext[p]  = {1'b0, ioctl_addr} - {1'b0, REGION_BASE[p*AW +: AW]};
            hit[p]      = ~off_ext[p][AW] & (off_ext[p] < {1'b0, REGION_SIZE[p*AW +: AW]});
            pend[p]     = port_req[p] ^ port_ack[p];
            iss[p]      = 1'b0;
            iss_a[p]    = '0;
            iss_ds[p]   = 2'b00;
            iss_d[p]    = 16'h0000;
            hold_ld[p]  = 1'b0;
            hold_clr[p] = 1'b0;
            if (state == LOAD && strobe && hit[p]) begin
                if (!PACK) begin
                    iss[p]    = 1'b1;
                    iss_a[p]  = off_ext[p][AW-1:1];
                    iss_ds[p] = {off_ext[p][0], ~off_ext[p][0]};
                    iss_d[p]  = {ioctl_dout, ioctl_dout};
                end else if (!off_ext[p][0]) begin
                    hold_ld[p] = 1'b1;
                    if (hold_v[p]) begin
                        iss[p]    = 1'b1;
                        iss_a[p]  = hold_a[p];
                        iss_ds[p] = 2'b01;
                        iss_d[p]  = {hold_d[p], hold_d[p]};
                    end
                end else if (hold_v[p] && hold_a[p] == off_ext[p][AW-1:1]) begin
                    iss[p]      = 1'b1;
                    iss_a[p]    = hold_a[p];
                    iss_ds[p]   = 2'b11;
                    iss_d[p]    = {ioctl_dout, hold_d[p]};
                    hold_clr[p] = 1'b1;
                end else begin
                    iss[p]    = 1'b1;
                    iss_a[p]  = off_ext[p][AW-1:1];
                    iss_ds[p] = 2'b10;
                    iss_d[p]  = {ioctl_dout, ioctl_dout};
                end
            end else if (state == FLUSH && !dl_rise && hold_v[p] && !pend[p]) begin
                iss[p]      = 1'b1;
                iss_a[p]    = hold_a[p];
                iss_ds[p]   = 2'b01;
                iss_d[p]    = {hold_d[p], hold_d[p]};
                hold_clr[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            wr_last    <= 1'b0;
            dl_act_q   <= 1'b0;
            port_req   <= '0;
            port_we    <= '0;
            port_a     <= '0;
            port_ds    <= '0;
            port_d     <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
            overrun    <= 1'b0;
            hold_v     <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                hold_a[p] <= '0;
                hold_d[p] <= 8'h00;
            end
        end else begin
            wr_last    <= ioctl_wr;
            dl_act_q   <= dl_act;
            port_we    <= {NPORTS{dl_act}};
            core_reset <= ext_reset | ~rom_loaded | dl_act;

            for (int p = 0; p < NPORTS; p++) begin
                if (iss[p]) begin
                    if (pend[p]) begin
                        overrun <= 1'b1;
                    end else begin
                        port_req[p]                 <= ~port_req[p];
                        port_a[p*(AW-1) +: (AW-1)]  <= iss_a[p];
                        port_ds[p*2 +: 2]           <= iss_ds[p];
                        port_d[p*16 +: 16]          <= iss_d[p];
                    end
                end
                if (dl_rise) begin
                    hold_v[p] <= 1'b0;
                end else if (hold_ld[p]) begin
                    hold_v[p] <= 1'b1;
                    hold_a[p] <= off_ext[p][AW-1:1];
                    hold_d[p] <= ioctl_dout;
                end else if (hold_clr[p]) begin
                    hold_v[p] <= 1'b0;
                end
            end

            case (state)
                LOAD:    if (!dl_act) state <= FLUSH;
                FLUSH:   if (hold_v == '0) state <= DRAIN;
                DRAIN:   if (pend == '0) state <= DONE;
                DONE: begin
                    rom_loaded <= 1'b1;
                    state      <= IDLE;
                end
                default: ;
            endcase

            // A new download start wins over anything above, including a mid-flush abort.
            if (dl_rise) begin
                state      <= LOAD;
                rom_loaded <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dl_port_router.sv
// Directed bench: one PACK=0 and one PACK=1 router share the ioctl stimulus,
// each with its own delayed-ack SDRAM stand-in.
module tb_dl_port_router;

    logic        clk_sys = 1'b0;
    logic        res_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ext_reset;
    logic        ack_hold;

    logic [1:0]  p0_req, p0_ack, p0_ack_d, p0_we;
    logic [47:0] p0_a;
    logic [3:0]  p0_ds;
    logic [31:0] p0_d;
    logic        p0_rom, p0_crst, p0_ovr;

    logic [1:0]  p1_req, p1_ack, p1_ack_d, p1_we;
    logic [47:0] p1_a;
    logic [3:0]  p1_ds;
    logic [31:0] p1_d;
    logic        p1_rom, p1_crst, p1_ovr;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk_sys = ~clk_sys;

    dl_port_router #(.PACK(1'b0)) u_p0 (
        .clk_sys(clk_sys), .res_n(res_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .port_req(p0_req),
        .port_ack(p0_ack), .port_we(p0_we), .port_a(p0_a), .port_ds(p0_ds),
        .port_d(p0_d), .rom_loaded(p0_rom), .core_reset(p0_crst), .overrun(p0_ovr)
    );

    dl_port_router #(.PACK(1'b1)) u_p1 (
        .clk_sys(clk_sys), .res_n(res_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ext_reset(ext_reset), .port_req(p1_req),
        .port_ack(p1_ack), .port_we(p1_we), .port_a(p1_a), .port_ds(p1_ds),
        .port_d(p1_d), .rom_loaded(p1_rom), .core_reset(p1_crst), .overrun(p1_ovr)
    );

    // SDRAM stand-in: ack follows req two cycles later unless frozen.
    always @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            p0_ack_d <= 2'b00; p0_ack <= 2'b00;
            p1_ack_d <= 2'b00; p1_ack <= 2'b00;
        end else begin
            p0_ack_d <= p0_req;
            p1_ack_d <= p1_req;
            if (!ack_hold) begin
                p0_ack <= p0_ack_d;
                p1_ack <= p1_ack_d;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_both_loaded(input string tag);
        n = 0;
        while (!(p0_rom && p1_rom) && n < 40) begin
            tick();
            n++;
        end
        check(tag, {p0_rom, p1_rom}, 2'b11);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = 8'h00; ext_reset = 1'b0; ack_hold = 1'b0;
        tick(); tick();

        check("rst_req",   p0_req, 2'b00);
        check("rst_we",    p0_we, 2'b00);
        check("rst_a",     p0_a, 48'h0);
        check("rst_ds",    p0_ds, 4'h0);
        check("rst_d",     p0_d, 32'h0);
        check("rst_rom",   p0_rom, 1'b0);
        check("rst_crst",  p0_crst, 1'b1);
        check("rst_ovr",   p0_ovr, 1'b0);
        check("rst_req_p", p1_req, 2'b00);
        res_n = 1'b1;
        tick();

        // Unpacked byte routing; packed instance pairs the same two bytes.
        ioctl_download = 1'b1;
        tick();
        check("we_on", p0_we, 2'b11);
        wr_byte(25'h00000, 8'hAA);
        check("u_req0",  p0_req, 2'b01);
        check("u_a0",    p0_a[23:0], 24'h0);
        check("u_ds0",   p0_ds[1:0], 2'b01);
        check("u_d0",    p0_d[15:0], 16'hAAAA);
        check("p_hold",  p1_req, 2'b00);
        repeat (4) tick();
        wr_byte(25'h00001, 8'h55);
        check("u_req1",  p0_req, 2'b00);
        check("u_ds1",   p0_ds, 4'b0010);
        check("u_d1",    p0_d, 32'h0000_5555);
        check("u_a1",    p0_a, 48'h0);
        check("p_req01", p1_req, 2'b01);
        check("p_ds01",  p1_ds[1:0], 2'b11);
        check("p_d01",   p1_d[15:0], 16'h55AA);
        repeat (4) tick();

        // Packed pair into port 1's window; 0x0E000 lies just outside port 0.
        wr_byte(25'h0E000, 8'h12);
        check("p_e000_hold", p1_req, 2'b01);
        repeat (4) tick();
        wr_byte(25'h0E001, 8'h34);
        check("p_req_e001", p1_req, 2'b11);
        check("p_a1",       p1_a[47:24], 24'h0);
        check("p_ds1",      p1_ds[3:2], 2'b11);
        check("p_d1",       p1_d[31:16], 16'h3412);
        repeat (4) tick();

        // Lone even byte flushed after the download ends.
        wr_byte(25'h00004, 8'h77);
        check("p_lone_hold", p1_req, 2'b11);
        repeat (4) tick();
        ioctl_download = 1'b0;
        n = 0;
        while (!p1_rom && n < 20) begin
            tick();
            n++;
        end
        check("flush_rom",   p1_rom, 1'b1);
        check("flush_req",   p1_req, 2'b10);
        check("flush_a",     p1_a[23:0], 24'h2);
        check("flush_ds",    p1_ds[1:0], 2'b01);
        check("flush_d",     p1_d[7:0], 8'h77);
        check("crst_hold",   p1_crst, 1'b1);
        tick();
        check("crst_fall",   p1_crst, 1'b0);
        check("u_rom",       p0_rom, 1'b1);

        // Overrun: ack frozen, second write to the same port is dropped.
        ack_hold = 1'b1;
        ioctl_download = 1'b1;
        tick();
        check("ov_clr_start", p0_ovr, 1'b0);
        check("rom_clr",      p0_rom, 1'b0);
        wr_byte(25'h00010, 8'h01);
        check("ov_req1", p0_req, 2'b00);
        check("ov_a1",   p0_a[23:0], 24'h8);
        repeat (2) tick();
        wr_byte(25'h00012, 8'h02);
        check("ov_req2", p0_req, 2'b00);
        check("ov_d2",   p0_d[15:0], 16'h0101);
        check("ov_a2",   p0_a[23:0], 24'h8);
        check("ov_set",  p0_ovr, 1'b1);
        ack_hold = 1'b0;
        repeat (4) tick();
        ioctl_download = 1'b0;
        wait_both_loaded("ov_loaded");
        check("ov_sticky", p0_ovr, 1'b1);
        ioctl_download = 1'b1;
        tick();
        check("ov_clear",  p0_ovr, 1'b0);
        check("dl_crst",   p0_crst, 1'b1);

        // Strobe level held for 10 cycles produces a single request.
        ioctl_addr = 25'h00020;
        ioctl_dout = 8'h99;
        ioctl_wr   = 1'b1;
        repeat (10) tick();
        ioctl_wr   = 1'b0;
        tick();
        check("held_req", p0_req, 2'b01);
        check("held_a",   p0_a[23:0], 24'h10);
        check("held_d",   p0_d[15:0], 16'h9999);
        ioctl_download = 1'b0;
        wait_both_loaded("held_loaded");

        // Foreign index is ignored.
        ioctl_index = 8'd1;
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'h00000, 8'hAA);
        repeat (3) tick();
        check("idx_req0", p0_req, 2'b01);
        check("idx_req1", p1_req, 2'b11);
        check("idx_rom",  p0_rom, 1'b1);
        check("idx_we",   p0_we, 2'b00);
        check("idx_crst", p0_crst, 1'b0);
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        tick();

        // ext_reset forces core reset without touching rom_loaded.
        ext_reset = 1'b1;
        tick();
        check("ext_crst", p0_crst, 1'b1);
        check("ext_rom",  p0_rom, 1'b1);
        ext_reset = 1'b0;
        tick();
        check("ext_rel",  p0_crst, 1'b0);

        // Asynchronous reset in the middle of a download.
        ioctl_download = 1'b1;
        tick();
        wr_byte(25'h00031, 8'h5A);
        repeat (2) tick();
        res_n = 1'b0;
        #1;
        check("ar_req0", p0_req, 2'b00);
        check("ar_req1", p1_req, 2'b00);
        check("ar_rom",  p0_rom, 1'b0);
        check("ar_crst", p0_crst, 1'b1);
        check("ar_a",    p1_a, 48'h0);
        ioctl_download = 1'b0;
        tick();
        res_n = 1'b1;
        repeat (5) tick();
        check("ar_rom_after",  {p0_rom, p1_rom}, 2'b00);
        check("ar_crst_after", p0_crst, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
